arr_collect: RTL and testbench

- Reader at the far end of the indexed-array register's emit/data/ready stream.
- On `start`, it rewinds the source's read counter and issues emit pulses.
- It captures the registered words the source returns and packs them into one parallel result word.
- The result is held with a valid/ack handshake for the downstream consumer, such as the simulator state loader.

---
 rtl/arr_collect_pkg.sv | 15 +
 rtl/arr_collect_buf.sv | 30 +++
 rtl/arr_collect.sv | 103 ++++++++++
 tb/tb_arr_collect.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/arr_collect_pkg.sv
// Shared definitions for the indexed-array reader and the array register it drains.
package arr_collect_pkg;

   localparam int ARR_DEPTH = 4;
   localparam int ARR_DW    = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REWIND = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HOLD   = 3'd4
   } state_t;

endpackage

// File: rtl/arr_collect_buf.sv
// Capture buffer: N_WORDS x DW words with indexed write and clear, presented as one packed word.
module arr_collect_buf
   import arr_collect_pkg::*;
#(
   parameter int N_WORDS = ARR_DEPTH,
   parameter int DW      = ARR_DW,
   parameter int CW      = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   wr,
   input  logic [CW-1:0]          idx,
   input  logic [DW-1:0]          din,
   output logic [N_WORDS*DW-1:0]  words
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words <= '0;
      end else if (clr) begin
         words <= '0;
      end else if (wr) begin
         for (int i = 0; i < N_WORDS; i++) begin
            if (idx == CW'(i)) words[i*DW +: DW] <= din;
         end
      end
   end

endmodule

// File: rtl/arr_collect.sv
// Reads a full indexed-array register (rewind, emit strobes, registered capture) and
// holds the packed result under a valid/ack handshake.
module arr_collect
   import arr_collect_pkg::*;
#(
   parameter int N_WORDS = ARR_DEPTH,
   parameter int DW      = ARR_DW,
   parameter int CW      = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stall,
   output logic                   src_rst,
   output logic                   emit,
   input  logic [DW-1:0]          src_data,
   input  logic                   src_ready,
   output logic [N_WORDS*DW-1:0]  words,
   output logic                   out_valid,
   input  logic                   out_ack,
   output logic                   busy,
   output logic                   err_short
);

   localparam logic [CW-1:0] LAST = CW'(N_WORDS - 1);

   state_t         state;
   state_t         state_nx;
   logic [CW-1:0]  iss;
   logic [CW-1:0]  cap;
   logic           emit_q;
   logic           clr;
   logic           capture;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // DRAIN leaves on the final capture itself so out_valid follows it with no idle cycle.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (start) state_nx = ST_REWIND;
         ST_REWIND: state_nx = ST_ISSUE;
         ST_ISSUE:  if (!stall && iss == LAST) state_nx = ST_DRAIN;
         ST_DRAIN:  if (emit_q && cap == LAST) state_nx = ST_HOLD;
         ST_HOLD:   if (out_ack) state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      emit      = 1'b0;
      src_rst   = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         ST_IDLE:   busy = 1'b0;
         ST_REWIND: src_rst = 1'b1;
         ST_ISSUE:  emit = !stall;
         ST_HOLD:   out_valid = 1'b1;
         default:   ;
      endcase
   end

   assign clr     = (state == ST_IDLE) && start;
   assign capture = emit_q && (state == ST_ISSUE || state == ST_DRAIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss       <= '0;
         cap       <= '0;
         emit_q    <= 1'b0;
         err_short <= 1'b0;
      end else begin
         emit_q <= emit;
         if (clr) begin
            iss       <= '0;
            cap       <= '0;
            err_short <= 1'b0;
         end else begin
            if (emit) iss <= iss + 1'b1;
            if (capture) begin
               cap <= cap + 1'b1;
               if (!src_ready) err_short <= 1'b1;
            end
         end
      end
   end

   // A word the source failed to deliver is recorded as zero.
   arr_collect_buf #(.N_WORDS(N_WORDS), .DW(DW), .CW(CW)) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .wr    (capture),
      .idx   (cap),
      .din   (src_ready ? src_data : '0),
      .words (words)
   );

endmodule

// File: tb/tb_arr_collect.sv
// Bench for arr_collect: behavioural source array plus a transaction-level expectation model.
module tb_arr_collect;
   import arr_collect_pkg::*;

   localparam int NW = ARR_DEPTH;
   localparam int DW = ARR_DW;
   localparam int WW = NW * DW;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic           stall;
   logic           src_rst;
   logic           emit;
   logic [DW-1:0]  src_data = '0;
   logic           src_ready = 1'b1;
   logic [WW-1:0]  words;
   logic           out_valid;
   logic           out_ack;
   logic           busy;
   logic           err_short;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   arr_collect #(.N_WORDS(NW), .DW(DW), .CW(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stall     (stall),
      .src_rst   (src_rst),
      .emit      (emit),
      .src_data  (src_data),
      .src_ready (src_ready),
      .words     (words),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .busy      (busy),
      .err_short (err_short)
   );

   // Source array register: read pointer rewound by src_rst (unless tied off), exhausted -> ready=0.
   logic [DW-1:0] mem [NW];
   int            src_ptr = 0;
   bit            rewind_en = 1'b1;

   always @(posedge clk) begin
      if (src_rst && rewind_en) begin
         src_ptr <= 0;
      end else if (emit) begin
         if (src_ptr < NW) begin
            src_data  <= mem[src_ptr];
            src_ready <= 1'b1;
            src_ptr   <= src_ptr + 1;
         end else begin
            src_data  <= $urandom;
            src_ready <= 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit pick_stall(input int mode, input int cyc);
      case (mode)
         0:       return 1'b0;
         1:       return (cyc == 3 || cyc == 4);
         default: return ($urandom_range(0, 99) < 40);
      endcase
   endfunction

   function automatic bit noise_bit(input bit en);
      return en && ($urandom_range(0, 1) == 1);
   endfunction

   // One full transaction from IDLE, starting at the beginning of a cycle.
   task automatic run_txn(input int mode, input bit rew, input int ack_dly,
                          input bit noise, input bit ack_start);
      logic [WW-1:0] exp_w;
      bit            exp_err;
      int            ptr0;
      int            n;
      int            cyc;
      rewind_en = rew;
      ptr0      = rew ? 0 : src_ptr;
      exp_err   = 1'b0;
      exp_w     = '0;
      for (int i = 0; i < NW; i++) begin
         if (ptr0 + i < NW) exp_w[i*DW +: DW] = mem[ptr0 + i];
         else exp_err = 1'b1;
      end

      start = 1'b1; stall = pick_stall(2, 0); out_ack = 1'b0;
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_valid", out_valid, 0);
      step();

      cyc = 1;
      start = noise_bit(noise); stall = pick_stall(mode, cyc); out_ack = noise_bit(noise);
      @(negedge clk);
      check("rewind_src_rst", src_rst, 1);
      check("rewind_emit", emit, 0);
      check("rewind_busy", busy, 1);
      check("start_clears_err", err_short, 0);
      step();

      cyc = 2; n = 0;
      while (n < NW && cyc < 300) begin
         start = noise_bit(noise); stall = pick_stall(mode, cyc); out_ack = noise_bit(noise);
         @(negedge clk);
         check("issue_emit", emit, !stall);
         check("issue_src_rst", src_rst, 0);
         check("issue_valid", out_valid, 0);
         if (!stall) n++;
         step();
         cyc++;
      end
      if (n < NW) check("issue_timeout", n, NW);

      start = noise_bit(noise); stall = pick_stall(2, cyc); out_ack = noise_bit(noise);
      @(negedge clk);
      check("drain_emit", emit, 0);
      check("drain_valid", out_valid, 0);
      check("drain_busy", busy, 1);
      step();

      start = 1'b0; stall = pick_stall(2, cyc); out_ack = 1'b0;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_words", words, exp_w);
      check("hold_err", err_short, exp_err);
      check("hold_emit", emit, 0);
      for (int d = 0; d < ack_dly; d++) begin
         step();
         start = noise_bit(noise);
         @(negedge clk);
         check("wait_valid", out_valid, 1);
         check("wait_words", words, exp_w);
      end
      step();

      out_ack = 1'b1; start = ack_start;
      @(negedge clk);
      check("ack_valid", out_valid, 1);
      step();

      out_ack = 1'b0; start = 1'b0;
      @(negedge clk);
      check("post_valid", out_valid, 0);
      check("post_busy", busy, 0);
      check("post_words", words, exp_w);
      check("post_err", err_short, exp_err);
      step();
      @(negedge clk);
      check("post_no_rewind", src_rst, 0);
      check("post_idle", busy, 0);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; stall = 1'b0; out_ack = 1'b0;
      mem[0] = 32'h11111111; mem[1] = 32'h22222222;
      mem[2] = 32'h33333333; mem[3] = 32'h44444444;
      step();
      @(negedge clk);
      check("rst_emit", emit, 0);
      check("rst_src_rst", src_rst, 0);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_short, 0);
      check("rst_words", words, 0);
      #2 rst_n = 1'b1;
      step();

      run_txn(0, 1'b1, 0, 1'b0, 1'b0);     // basic read
      run_txn(1, 1'b1, 0, 1'b0, 1'b0);     // stall in cycles 3 and 4
      run_txn(0, 1'b0, 0, 1'b0, 1'b0);     // source not rewound: short
      run_txn(0, 1'b1, 5, 1'b0, 1'b1);     // err cleared, long hold, ack with start

      // Async reset after two emits.
      rewind_en = 1'b1;
      start = 1'b1; step();
      start = 1'b0; step();
      step(); step();
      rst_n = 1'b0;
      #1;
      check("arst_emit", emit, 0);
      check("arst_busy", busy, 0);
      check("arst_words", words, 0);
      check("arst_valid", out_valid, 0);
      step(); step();
      #2 rst_n = 1'b1;
      step();
      run_txn(0, 1'b1, 1, 1'b0, 1'b0);

      run_txn(0, 1'b1, 1, 1'b1, 1'b0);     // start/ack noise while busy

      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < NW; i++) mem[i] = $urandom;
         run_txn(2, ($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
